// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared types and sizes for the register-file write path
package rf_ctrl_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_WB,
      SRC_MD,
      SRC_DBG
   } src_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write mask for multi-cycle destinations
// A set and a clear of the same register on one edge leave it busy.
module rf_scoreboard
   import rf_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              setEn,
   input  logic [REG_AW-1:0] setIdx,
   input  logic              clrEn,
   input  logic [REG_AW-1:0] clrIdx,
   input  logic [REG_AW-1:0] lookA,
   input  logic [REG_AW-1:0] lookB,
   output logic              busyA,
   output logic              busyB
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] setMask;
   logic [NREG-1:0] clrMask;

   // x0 is never tracked, so bit 0 stays clear
   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (setEn && setIdx != '0) setMask[setIdx] = 1'b1;
      if (clrEn && clrIdx != '0) clrMask[clrIdx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= (busy & ~clrMask) | setMask;
   end

   assign busyA = (lookA != '0) && busy[lookA];
   assign busyB = (lookB != '0) && busy[lookB];

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port owner and arbiter
// Clears x1..x31 after reset, then grants WB > MD > DBG with a registered write.
module regfile_write_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter bit INIT_CLEAR   = 1'b1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              md_valid,
   input  logic [REG_AW-1:0] md_rd,
   input  logic [XLEN-1:0]   md_data,
   output logic              md_ready,
   input  logic              dbg_valid,
   input  logic [REG_AW-1:0] dbg_rd,
   input  logic [XLEN-1:0]   dbg_data,
   output logic              dbg_ready,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   output logic              hz_stall,
   output logic              wb_hold,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              init_done
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t            state;
   state_t            stateNext;
   src_t              grant;
   src_t              rfSrc;
   logic [REG_AW-1:0] initCnt;
   logic [SW-1:0]     starveCnt;
   logic              isRun;
   logic              wbReq;
   logic              mdFire;
   logic              dbgFire;
   logic              busyRs1;
   logic              busyRs2;

   assign isRun     = (state == RUN);
   assign wbReq     = wb_we && (wb_rd != '0);
   assign md_ready  = isRun && !wbReq;
   assign dbg_ready = isRun && !wbReq && !md_valid;
   assign mdFire    = md_valid && md_ready;
   assign dbgFire   = dbg_valid && dbg_ready;

   // x0 handshakes complete but never claim the port
   always_comb begin
      stateNext = state;
      grant     = SRC_NONE;
      case (state)
         INIT: if (initCnt == REG_AW'(NREG - 1)) stateNext = RUN;
         RUN: begin
            if (wbReq)                        grant = SRC_WB;
            else if (mdFire && md_rd != '0)   grant = SRC_MD;
            else if (dbgFire && dbg_rd != '0) grant = SRC_DBG;
         end
         default: stateNext = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT_CLEAR ? INIT : RUN;
         initCnt   <= REG_AW'(1);
         init_done <= 1'b0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         rfSrc     <= SRC_NONE;
      end else begin
         state     <= stateNext;
         init_done <= init_done || isRun;
         if (state == INIT) begin
            initCnt  <= initCnt + REG_AW'(1);
            rf_we    <= 1'b1;
            rf_waddr <= initCnt;
            rf_wdata <= '0;
            rfSrc    <= SRC_NONE;
         end else begin
            rf_we <= (grant != SRC_NONE);
            rfSrc <= grant;
            case (grant)
               SRC_WB: begin
                  rf_waddr <= wb_rd;
                  rf_wdata <= wb_data;
               end
               SRC_MD: begin
                  rf_waddr <= md_rd;
                  rf_wdata <= md_data;
               end
               SRC_DBG: begin
                  rf_waddr <= dbg_rd;
                  rf_wdata <= dbg_data;
               end
               default: ;
            endcase
         end
      end
   end

   // Denied MD cycles accumulate until WB is told to skip one slot
   always_ff @(posedge clk) begin
      if (reset) begin
         starveCnt <= '0;
         wb_hold   <= 1'b0;
      end else begin
         wb_hold <= 1'b0;
         if (mdFire) begin
            starveCnt <= '0;
         end else if (md_valid) begin
            if (starveCnt + SW'(1) == SW'(STARVE_LIMIT)) begin
               starveCnt <= '0;
               wb_hold   <= 1'b1;
            end else begin
               starveCnt <= starveCnt + SW'(1);
            end
         end
      end
   end

   rf_scoreboard u_scoreboard (
      .clk    (clk),
      .reset  (reset),
      .setEn  (iss_valid),
      .setIdx (iss_rd),
      .clrEn  (rf_we && rfSrc == SRC_MD),
      .clrIdx (rf_waddr),
      .lookA  (rs1),
      .lookB  (rs2),
      .busyA  (busyRs1),
      .busyB  (busyRs2)
   );

   assign hz_stall = !isRun || busyRs1 || busyRs2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
   import rf_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              wb_we;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              md_valid;
   logic [REG_AW-1:0] md_rd;
   logic [XLEN-1:0]   md_data;
   logic              md_ready;
   logic              dbg_valid;
   logic [REG_AW-1:0] dbg_rd;
   logic [XLEN-1:0]   dbg_data;
   logic              dbg_ready;
   logic              iss_valid;
   logic [REG_AW-1:0] iss_rd;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic              hz_stall;
   logic              wb_hold;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;
   logic              init_done;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.STARVE_LIMIT(4), .INIT_CLEAR(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .md_valid  (md_valid),
      .md_rd     (md_rd),
      .md_data   (md_data),
      .md_ready  (md_ready),
      .dbg_valid (dbg_valid),
      .dbg_rd    (dbg_rd),
      .dbg_data  (dbg_data),
      .dbg_ready (dbg_ready),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .hz_stall  (hz_stall),
      .wb_hold   (wb_hold),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .init_done (init_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      wb_we = 1'b0;  wb_rd = '0;  wb_data = '0;
      md_valid = 1'b0; md_rd = '0; md_data = '0;
      dbg_valid = 1'b0; dbg_rd = '0; dbg_data = '0;
      iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;

      // reset and clear sweep
      step;
      reset = 1'b0;
      #1;
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_wb_hold", 64'(wb_hold), 64'd0);
      chk("rst_init_done", 64'(init_done), 64'd0);
      chk("init_hz_stall", 64'(hz_stall), 64'd1);
      md_valid = 1'b1;
      dbg_valid = 1'b1;
      #1;
      chk("init_md_ready", 64'(md_ready), 64'd0);
      chk("init_dbg_ready", 64'(dbg_ready), 64'd0);
      md_valid = 1'b0;
      dbg_valid = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         step;
         chk("init_we", 64'(rf_we), 64'd1);
         chk("init_addr", 64'(rf_waddr), 64'(i));
         chk("init_data", 64'(rf_wdata), 64'd0);
      end
      chk("init_done_late", 64'(init_done), 64'd0);
      step;
      chk("init_done", 64'(init_done), 64'd1);
      chk("idle_rf_we", 64'(rf_we), 64'd0);
      chk("run_hz_stall", 64'(hz_stall), 64'd0);

      // WB and MD collide: WB first, MD one cycle later
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hA;
      md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hB;
      #1;
      chk("col_md_ready", 64'(md_ready), 64'd0);
      step;
      chk("col_wb_we", 64'(rf_we), 64'd1);
      chk("col_wb_addr", 64'(rf_waddr), 64'd5);
      chk("col_wb_data", 64'(rf_wdata), 64'hA);
      wb_we = 1'b0;
      #1;
      chk("col_md_ready2", 64'(md_ready), 64'd1);
      step;
      chk("col_md_we", 64'(rf_we), 64'd1);
      chk("col_md_addr", 64'(rf_waddr), 64'd7);
      chk("col_md_data", 64'(rf_wdata), 64'hB);
      md_valid = 1'b0;
      step;
      chk("col_idle_we", 64'(rf_we), 64'd0);
      chk("col_addr_hold", 64'(rf_waddr), 64'd7);

      // starvation: four denials raise wb_hold, then MD wins
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
      md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h88;
      for (int i = 1; i <= 3; i++) begin
         step;
         chk("stv_no_hold", 64'(wb_hold), 64'd0);
      end
      step;
      chk("stv_hold", 64'(wb_hold), 64'd1);
      chk("stv_wb_addr", 64'(rf_waddr), 64'd2);
      wb_we = 1'b0;
      #1;
      chk("stv_md_ready", 64'(md_ready), 64'd1);
      step;
      chk("stv_hold_drop", 64'(wb_hold), 64'd0);
      chk("stv_md_addr", 64'(rf_waddr), 64'd8);
      chk("stv_md_data", 64'(rf_wdata), 64'h88);
      md_valid = 1'b0;

      // scoreboard hazard on x9
      iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
      #1;
      chk("hz_before_set", 64'(hz_stall), 64'd0);
      step;
      iss_valid = 1'b0;
      #1;
      chk("hz_busy", 64'(hz_stall), 64'd1);
      step;
      chk("hz_busy2", 64'(hz_stall), 64'd1);
      md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
      #1;
      chk("hz_md_ready", 64'(md_ready), 64'd1);
      step;
      md_valid = 1'b0;
      chk("hz_rfwe_addr", 64'(rf_waddr), 64'd9);
      chk("hz_in_rfwe", 64'(hz_stall), 64'd1);
      step;
      chk("hz_cleared", 64'(hz_stall), 64'd0);
      rs1 = '0;

      // same-edge set and clear of x10 keeps it busy
      iss_valid = 1'b1; iss_rd = 5'd10; rs2 = 5'd10;
      step;
      iss_valid = 1'b0;
      md_valid = 1'b1; md_rd = 5'd10; md_data = 32'h10;
      step;
      md_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd10;
      chk("sc_rfwe_addr", 64'(rf_waddr), 64'd10);
      step;
      iss_valid = 1'b0;
      #1;
      chk("sc_set_wins", 64'(hz_stall), 64'd1);
      rs2 = '0;

      // x0 destinations and debug access
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h5;
      #1;
      chk("x0_md_ready", 64'(md_ready), 64'd1);
      step;
      chk("x0_md_no_we", 64'(rf_we), 64'd0);
      md_rd = 5'd4; md_data = 32'h44;
      dbg_valid = 1'b1; dbg_rd = 5'd3; dbg_data = 32'h33;
      #1;
      chk("dbg_blocked", 64'(dbg_ready), 64'd0);
      step;
      chk("dbg_md_addr", 64'(rf_waddr), 64'd4);
      md_valid = 1'b0;
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
      #1;
      chk("dbg_ready", 64'(dbg_ready), 64'd1);
      step;
      chk("dbg_we", 64'(rf_we), 64'd1);
      chk("dbg_addr", 64'(rf_waddr), 64'd3);
      chk("dbg_data", 64'(rf_wdata), 64'h33);
      wb_we = 1'b0;
      dbg_valid = 1'b0;

      // reset in the middle of the clear sweep
      reset = 1'b1;
      step;
      reset = 1'b0;
      for (int i = 1; i <= 9; i++) step;
      chk("mid_addr9", 64'(rf_waddr), 64'd9);
      reset = 1'b1;
      step;
      reset = 1'b0;
      chk("mid_rst_we", 64'(rf_we), 64'd0);
      chk("mid_rst_done", 64'(init_done), 64'd0);
      for (int i = 1; i <= 31; i++) begin
         step;
         chk("rst_sweep_addr", 64'(rf_waddr), 64'(i));
      end
      step;
      chk("rst_sweep_done", 64'(init_done), 64'd1);
      rs2 = 5'd10;
      #1;
      chk("rst_busy_clear", 64'(hz_stall), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
